// File: rtl/bf_uart_tx.sv
// rtl/bf_uart_tx.sv - FIFO-buffered UART transmitter for the core's '.' output strobe
// Optional even parity (8E1 frame) when BF_UART_TX_PARITY_EN is defined; otherwise 8N1.
module bf_uart_tx #(
    parameter int CLK_PER_BIT = 16,
    parameter int FIFO_LOG2   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sendingChar,
    input  logic [7:0] sendedChar,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = (FIFO_LOG2)'(1);
    localparam logic [15:0]          BAUD_MAX = 16'(CLK_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           mem_d [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic [2:0]           state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef BF_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 push, pop, baud_done;

    assign tx_ready  = (count_q != FULL_CNT);
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign push      = sendingChar && tx_ready;
    assign baud_done = (baud_q == 16'd0);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef BF_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                pop  = (count_q != '0);
            end
            S_START: begin
                if (baud_done) begin
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                    baud_d    = BAUD_MAX;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_MAX;
                    if (bit_idx_q == 3'd7) begin
`ifdef BF_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef BF_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    baud_d  = BAUD_MAX;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    // A queued byte starts its start bit on this same edge: no idle gap.
                    pop     = (count_q != '0);
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            tx_d     = 1'b0;
            state_d  = S_START;
            baud_d   = BAUD_MAX;
`ifdef BF_UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end

        if (push) begin
            mem_d[wr_ptr_q] = sendedChar;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef BF_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef BF_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_bf_uart_tx.sv
// tb/tb_bf_uart_tx.sv - self-checking bench for bf_uart_tx with a line-level UART decoder
// Honours BF_UART_TX_PARITY_EN to expect 8E1 frames instead of 8N1.
module tb_bf_uart_tx;
    localparam int CPB = 4;
`ifdef BF_UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sendingChar = 1'b0;
    logic [7:0] sendedChar = 8'h00;
    logic       tx_ready, tx, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_par[$];
    logic       rx_stop[$];

    bf_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_LOG2(2)) dut (
        .clk(clk), .reset(rst_n), .sendingChar(sendingChar), .sendedChar(sendedChar),
        .tx_ready(tx_ready), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: finds a start bit, then samples every bit at mid-bit.
    logic [7:0] mon_d;
    logic       mon_p, mon_s;
    int         mon_t0;
    always begin
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            mon_t0 = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_d[i] = tx;
            end
`ifdef BF_UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            mon_p = tx;
`else
            mon_p = ^mon_d;
`endif
            repeat (CPB) @(negedge clk);
            mon_s = tx;
            rx_q.push_back(mon_d);
            rx_t.push_back(mon_t0);
            rx_par.push_back(mon_p);
            rx_stop.push_back(mon_s);
            repeat (CPB - CPB / 2 - 1) @(negedge clk);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_clear();
        rx_q.delete(); rx_t.delete(); rx_par.delete(); rx_stop.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    // Compare the decoded stream against the expected bytes; frames must be back-to-back.
    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            chk({tag, "_data"}, 32'(rx_q[i]), 32'(exp[i]));
            chk({tag, "_stop"}, 32'(rx_stop[i]), 32'd1);
            chk({tag, "_par"}, 32'(rx_par[i]), 32'(^exp[i]));
            if (i > 0) chk({tag, "_gap"}, 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME));
        end
    endtask

    initial begin
        int p, lows, len;
        logic [7:0] exp_q[$];

        // 1: reset and idle line
        repeat (5) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("idle_lows", 32'(lows), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // 2: single byte, latency and busy duration
        rx_clear();
        sendingChar = 1'b1; sendedChar = 8'h55;
        @(negedge clk); p = cyc;
        sendingChar = 1'b0; sendedChar = $urandom();
        chk("t2_tx_push", 32'(tx), 32'd1);
        chk("t2_busy_push", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t2_tx_start", 32'(tx), 32'd0);
        repeat (FRAME - 1) @(negedge clk);
        chk("t2_busy_end", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t2_busy_fall", 32'(busy), 32'd0);
        wait_rx(1, 200);
        exp_q = '{8'h55};
        check_stream("t2", exp_q);
        if (rx_t.size() > 0) chk("t2_start_cyc", 32'(rx_t[0]), 32'(p + 1));

        // 3+4: fill FIFO, refused push, held push accepted once after the first pop
        rx_clear();
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        sendingChar = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sendedChar = exp_q[k];
            @(negedge clk);
            if (k == 0) p = cyc;
        end
        chk("t3_full", 32'(tx_ready), 32'd0);
        sendedChar = 8'hFF;
        @(negedge clk);
        sendedChar = 8'h46;
        while (cyc < p + FRAME + 2) begin
            @(negedge clk);
            if (cyc == p + FRAME)     chk("t4_ready_lo", 32'(tx_ready), 32'd0);
            if (cyc == p + FRAME + 1) chk("t4_ready_hi", 32'(tx_ready), 32'd1);
        end
        sendingChar = 1'b0;
        chk("t4_refull", 32'(tx_ready), 32'd0);
        exp_q.push_back(8'h46);
        wait_rx(6, 8 * FRAME);
        repeat (3 * FRAME) @(negedge clk);
        chk("t4_no_extra", 32'(rx_q.size()), 32'd6);
        check_stream("t34", exp_q);

        // 5: reset during data bit 3 of 0xA5 with two bytes queued
        rx_clear();
        sendingChar = 1'b1; sendedChar = 8'hA5;
        @(negedge clk); p = cyc;
        sendedChar = 8'h11; @(negedge clk);
        sendedChar = 8'h22; @(negedge clk);
        sendingChar = 1'b0;
        while (cyc < p + 1 + 4 * CPB + 1) @(negedge clk);
        chk("t5_bit3", 32'(tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_tx", 32'(tx), 32'd1);
        chk("t5_async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        rx_clear();
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("t5_lows", 32'(lows), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(tx_ready), 32'd1);
        chk("t5_rx", 32'(rx_q.size()), 32'd0);

`ifdef BF_UART_TX_PARITY_EN
        // 6: parity bit values and 11-bit frame spacing
        rx_clear();
        exp_q = '{8'h07, 8'h03};
        sendingChar = 1'b1;
        sendedChar = 8'h07; @(negedge clk);
        sendedChar = 8'h03; @(negedge clk);
        sendingChar = 1'b0;
        wait_rx(2, 4 * FRAME);
        if (rx_par.size() == 2) begin
            chk("t6_par07", 32'(rx_par[0]), 32'd1);
            chk("t6_par03", 32'(rx_par[1]), 32'd0);
        end
        check_stream("t6", exp_q);
        repeat (2 * CPB) @(negedge clk);
`endif

        // Random bursts on consecutive edges from an idle transmitter
        for (int b = 0; b < 6; b++) begin
            rx_clear();
            exp_q.delete();
            len = $urandom_range(1, 5);
            sendingChar = 1'b1;
            for (int k = 0; k < len; k++) begin
                sendedChar = 8'($urandom());
                exp_q.push_back(sendedChar);
                @(negedge clk);
            end
            sendingChar = 1'b0;
            sendedChar = 8'($urandom());
            chk("rnd_ready", 32'(tx_ready), (len == 5) ? 32'd0 : 32'd1);
            wait_rx(len, (len + 2) * FRAME);
            check_stream("rnd", exp_q);
            repeat (2 * CPB) @(negedge clk);
            chk("rnd_idle", 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
